count_checker: RTL and testbench
================================

# count_checker

Sampling monitor that sits on the output bus of a free-running up-counter and checks that it advances by exactly one per sampled clock, with 2^WIDTH−1 → 0 wrap-around. It acquires lock after a run of consecutive good steps. Once locked, it flags each bad step with a one-cycle pulse, a saturating error count and a capture of the offending value. It is the reader-side companion to the counter block, used both as an on-chip health monitor and as a self-checking element in counter benches.

## Interface
- WIDTH, 8, width of the observed counter value
- LOCK_CNT, 2, consecutive good steps required to enter LOCK (≥1)
- ERR_W, 8, width of the error counter
- clk  in  1  clock; all sampling on the rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  sample enable; cnt is checked only on edges where en=1
- cnt  in  WIDTH  counter value under observation
- locked  out  1  high while in LOCK
- err_pulse  out  1  one-cycle pulse per bad step detected in LOCK
- err_cnt  out  ERR_W  saturating count of err_pulse events
- last_bad  out  WIDTH  cnt value that caused the most recent error
- state  out  2  current FSM state, for debug

## Operation
- Registers: prev (WIDTH), run (step counter), FSM state.
- Good step: cnt == prev + 1, computed mod 2^WIDTH. prev = 2^WIDTH−1 followed by cnt = 0 is good.
- IDLE (0):
  - en=1: prev←cnt, run←0, go to ACQ.
  - en=0: stay in IDLE.
- ACQ (1), each edge with en=1:
  - Good step: run←run+1. When run+1 == LOCK_CNT, go to LOCK and set locked.
  - Bad step: run←0 and stay in ACQ. No error is reported.
  - prev←cnt always.
- LOCK (2), each edge with en=1:
  - Good step: stay in LOCK.
  - Bad step: err_pulse←1, err_cnt←sat(err_cnt+1), last_bad←cnt, run←0, locked←0, go to ACQ.
  - prev←cnt always.
- State 3 is unused; it must recover to IDLE on the next edge.
- en=0 in ACQ or LOCK: go to IDLE next edge; locked←0; err_cnt and last_bad hold; err_pulse←0.
- err_cnt saturates at 2^ERR_W−1. Further errors still pulse err_pulse and update last_bad.

## Timing
- Reset (rst=0): immediate asynchronous clear. state=IDLE, locked=0, err_pulse=0, err_cnt=0, last_bad=0, prev=0, run=0.
- Reset deasserted mid-sequence: restarts acquisition from IDLE; no error is reported on the first sample.
- Latency:
  - err_pulse, err_cnt, last_bad and locked update on the same rising edge that samples cnt.
  - All outputs are registered; nothing is combinational from cnt.
- Lock timing with en held high: locked rises on the edge of sample LOCK_CNT+1 (the first sample only seeds prev).
- err_pulse is high for exactly one cycle per bad step. Back-to-back bad steps give one pulse, because the block is in ACQ after the first one.
- Simultaneous events:
  - Bad step on the edge where en falls: the step is not checked.
  - Bad step on the edge that would reach LOCK_CNT: stay in ACQ.

## Configuration
- COUNT_CHECKER_HOLD_EN
  - Defined: cnt == prev (counter held) is neutral in ACQ and LOCK. run is unchanged, no error is raised, and prev is unchanged. This supports counters with a stall/enable.
  - Undefined: a held value is a bad step.

## Structure
- Package count_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_ACQ=2'd1, ST_LOCK=2'd2
  - default WIDTH/ERR_W constants, shared with the counter block
- Sub-module sat_counter (parameter W; inputs inc and clr; output value) implements err_cnt saturation. It is reusable for run.
- Top level holds the FSM, the prev register and the step comparator.

## Test plan
- Counter from reset, en=1, cnt 0,1,2,3 with LOCK_CNT=2 → locked rises on the edge sampling 2; err_cnt=0.
- Locked, cnt 10,11,15,16 → single err_pulse on the edge sampling 15; last_bad=15, err_cnt=1, locked=0; locked returns after 16,17.
- Wrap: cnt 254,255,0,1 while locked → no error; locked stays 1.
- Hold: cnt 5,6,6,7 while locked → without the macro, error at the second 6 (last_bad=6); with COUNT_CHECKER_HOLD_EN, no error and locked stays 1.
- Saturation: ERR_W=2, force 5 separate lock-then-error sequences → err_cnt sticks at 3; err_pulse still fires 5 times.
- Mid-operation: while locked, rst=0 for half a cycle → all outputs clear immediately; after release, the first sample raises no error and lock is reacquired after LOCK_CNT good steps.

Source files
------------

// File: rtl/count_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_pkg
// Description : Shared definitions for the counter block and count_checker:
//               FSM state encodings and default datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package count_pkg;

    // Default widths, shared with the counter block
    localparam int DEF_WIDTH = 8;
    localparam int DEF_ERR_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACQ    = 2'd1;
    localparam state_t ST_LOCK   = 2'd2;
    localparam state_t ST_UNUSED = 2'd3;

endpackage : count_pkg
`default_nettype wire

// File: rtl/count_checker_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value.
//               clr has priority over inc.
// Ports       : clk   - clock
//               rst   - asynchronous active-low reset (clears value)
//               inc   - increment by one unless already saturated
//               clr   - synchronous clear to zero
//               value - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] c_MAX = '1;
    localparam logic [W-1:0] c_ONE = W'(1);

    logic [W-1:0] r_value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc && (r_value != c_MAX)) begin
            r_value <= r_value + c_ONE;
        end
    end

    assign value = r_value;

endmodule : sat_counter
`default_nettype wire

// File: rtl/count_checker.sv
`default_nettype none
// ============================================================================
// Module      : count_checker
// Description : Sampling monitor for a free-running up-counter. Acquires lock
//               after LOCK_CNT consecutive +1 steps (mod 2^WIDTH), then flags
//               each bad step with a one-cycle pulse, a saturating error count
//               and a capture of the offending value.
// Macro       : COUNT_CHECKER_HOLD_EN - when defined, a repeated value
//               (cnt == prev) is neutral in ACQ and LOCK instead of a bad step.
// Ports       : clk       - clock, rising-edge sampling
//               rst       - asynchronous active-low reset
//               en        - sample enable
//               cnt       - counter value under observation
//               locked    - high while in LOCK
//               err_pulse - one-cycle pulse per bad step seen in LOCK
//               err_cnt   - saturating count of err_pulse events
//               last_bad  - cnt value of the most recent error
//               state     - FSM state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module count_checker
    import count_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] last_bad,
    output logic [1:0]       state
);

    // run only has to reach LOCK_CNT; saturation keeps it there harmlessly
    localparam int               c_RUN_W = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] c_ONE   = WIDTH'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_prev;
    logic               r_err_pulse;
    logic [WIDTH-1:0]   r_last_bad;
    logic [c_RUN_W-1:0] w_run;

    logic [WIDTH-1:0]   w_succ;
    logic               w_tracking;
    logic               w_good;
    logic               w_hold;
    logic               w_lock_reached;
    logic               w_err;
    logic               w_run_inc;
    logic               w_run_clr;
    logic               w_prev_ld;

    // ------------------------------------------------------------------
    // Step comparator
    // ------------------------------------------------------------------
    assign w_succ         = r_prev + c_ONE;   // wraps 2^WIDTH-1 -> 0
    assign w_tracking     = (r_state == ST_ACQ) || (r_state == ST_LOCK);
    assign w_good         = (cnt == w_succ);
    assign w_lock_reached = ((32'(w_run) + 32'd1) == 32'(LOCK_CNT));

`ifdef COUNT_CHECKER_HOLD_EN
    assign w_hold = w_tracking && (cnt == r_prev);
`else
    assign w_hold = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) w_state_nxt = ST_ACQ;
            end
            ST_ACQ: begin
                if (!en)                            w_state_nxt = ST_IDLE;
                else if (w_hold)                    w_state_nxt = ST_ACQ;
                else if (w_good && w_lock_reached)  w_state_nxt = ST_LOCK;
                else                                w_state_nxt = ST_ACQ;
            end
            ST_LOCK: begin
                if (!en)                    w_state_nxt = ST_IDLE;
                else if (w_hold || w_good)  w_state_nxt = ST_LOCK;
                else                        w_state_nxt = ST_ACQ;
            end
            default: w_state_nxt = ST_IDLE;   // unused encoding recovers
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_err     = 1'b0;
        w_run_inc = 1'b0;
        w_run_clr = 1'b0;
        w_prev_ld = 1'b0;

        if (!en || !w_tracking) begin
            // IDLE seeds with run=0; leaving ACQ/LOCK also restarts run
            w_run_clr = 1'b1;
        end else if (!w_hold) begin
            if (w_good) begin
                w_run_inc = (r_state == ST_ACQ);
            end else begin
                w_run_clr = 1'b1;
                w_err     = (r_state == ST_LOCK);
            end
        end

        // prev follows every enabled sample except held values and the
        // unused state, which only returns to IDLE
        w_prev_ld = en && (r_state != ST_UNUSED) && !w_hold;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev      <= '0;
            r_err_pulse <= 1'b0;
            r_last_bad  <= '0;
        end else begin
            r_err_pulse <= w_err;
            if (w_prev_ld) r_prev     <= cnt;
            if (w_err)     r_last_bad <= cnt;
        end
    end

    sat_counter #(
        .W     (c_RUN_W)
    ) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_run_inc),
        .clr   (w_run_clr),
        .value (w_run)
    );

    sat_counter #(
        .W     (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_err),
        .clr   (1'b0),
        .value (err_cnt)
    );

    assign locked    = (r_state == ST_LOCK);
    assign err_pulse = r_err_pulse;
    assign last_bad  = r_last_bad;
    assign state     = r_state;

endmodule : count_checker
`default_nettype wire

// File: tb/tb_count_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_checker
// Description : Directed self-checking bench for count_checker. A second
//               instance with ERR_W=2 shares the stimulus to exercise error
//               count saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] cnt;

    logic       locked,   s_locked;
    logic       err_pulse, s_err_pulse;
    logic [7:0] err_cnt;
    logic [1:0] s_err_cnt;
    logic [7:0] last_bad, s_last_bad;
    logic [1:0] state,    s_state;

    int n_asrt  = 0;
    int n_fail  = 0;
    int exp_err = 0;
    int exp_lb  = 0;

    count_checker #(.WIDTH(8), .LOCK_CNT(2), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .cnt(cnt),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .last_bad(last_bad), .state(state)
    );

    count_checker #(.WIDTH(8), .LOCK_CNT(2), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .cnt(cnt),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_cnt(s_err_cnt),
        .last_bad(s_last_bad), .state(s_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int st, input int lk,
                              input int pl, input int ec, input int lb);
        chk({tag, ".state"},     32'(state),     32'(st));
        chk({tag, ".locked"},    32'(locked),    32'(lk));
        chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(pl));
        chk({tag, ".err_cnt"},   32'(err_cnt),   32'(ec));
        chk({tag, ".last_bad"},  32'(last_bad),  32'(lb));
    endtask

    // Drive one sample and return 1 time unit after the sampling edge
    task automatic step(input logic e, input logic [7:0] v);
        en  = e;
        cnt = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        cnt = 8'd0;
        #2;
        expect_out("reset", 0, 0, 0, 0, 0);
        chk("reset.sat_err_cnt", 32'(s_err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Acquisition from reset: lock on the edge sampling 2
        step(1'b1, 8'd0);  expect_out("acq0", 1, 0, 0, 0, 0);
        step(1'b1, 8'd1);  expect_out("acq1", 1, 0, 0, 0, 0);
        step(1'b1, 8'd2);  expect_out("acq2", 2, 1, 0, 0, 0);
        step(1'b1, 8'd3);  expect_out("acq3", 2, 1, 0, 0, 0);
        for (int v = 4; v <= 11; v++) step(1'b1, 8'(v));
        expect_out("run11", 2, 1, 0, 0, 0);

        // Jump 11 -> 15 while locked
        step(1'b1, 8'd15);
        exp_err = 1; exp_lb = 15;
        expect_out("jump15", 1, 0, 1, exp_err, exp_lb);
        step(1'b1, 8'd16); expect_out("after16", 1, 0, 0, exp_err, exp_lb);
        step(1'b1, 8'd17); expect_out("relock17", 2, 1, 0, exp_err, exp_lb);

        // Wrap 255 -> 0 while locked
        step(1'b0, 8'd0);   expect_out("idle", 0, 0, 0, exp_err, exp_lb);
        step(1'b1, 8'd252);
        step(1'b1, 8'd253);
        step(1'b1, 8'd254); expect_out("lock254", 2, 1, 0, exp_err, exp_lb);
        step(1'b1, 8'd255); expect_out("wrap255", 2, 1, 0, exp_err, exp_lb);
        step(1'b1, 8'd0);   expect_out("wrap0",   2, 1, 0, exp_err, exp_lb);
        step(1'b1, 8'd1);   expect_out("wrap1",   2, 1, 0, exp_err, exp_lb);

        // Held value while locked
        for (int v = 2; v <= 6; v++) step(1'b1, 8'(v));
        step(1'b1, 8'd6);
`ifdef COUNT_CHECKER_HOLD_EN
        expect_out("hold6", 2, 1, 0, exp_err, exp_lb);
        step(1'b1, 8'd7);
        expect_out("hold7", 2, 1, 0, exp_err, exp_lb);
`else
        exp_err++; exp_lb = 6;
        expect_out("hold6", 1, 0, 1, exp_err, exp_lb);
        step(1'b1, 8'd7);
        expect_out("hold7", 1, 0, 0, exp_err, exp_lb);
`endif
        step(1'b1, 8'd8);  expect_out("relock8", 2, 1, 0, exp_err, exp_lb);

        // Back-to-back bad steps give a single pulse
        step(1'b1, 8'd50);
        exp_err++; exp_lb = 50;
        expect_out("bad50", 1, 0, 1, exp_err, exp_lb);
        step(1'b1, 8'd60); expect_out("bad60", 1, 0, 0, exp_err, exp_lb);
        step(1'b1, 8'd61);
        step(1'b1, 8'd62); expect_out("relock62", 2, 1, 0, exp_err, exp_lb);

        // Bad value on the edge where en falls is not checked
        step(1'b0, 8'd99); expect_out("enfall", 0, 0, 0, exp_err, exp_lb);

        // Repeated lock-then-error sequences: ERR_W=2 instance sticks at 3
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 8'd0);
            step(1'b1, 8'd100);
            step(1'b1, 8'd101);
            step(1'b1, 8'd102);
            chk("sat.locked", 32'(s_locked), 32'd1);
            step(1'b1, 8'd200);
            exp_err++; exp_lb = 200;
            chk("sat.dut_pulse", 32'(err_pulse), 32'd1);
            chk("sat.pulse", 32'(s_err_pulse), 32'd1);
        end
        chk("sat.err_cnt", 32'(s_err_cnt), 32'd3);
        chk("sat.last_bad", 32'(s_last_bad), 32'd200);
        expect_out("sat.main", 1, 0, 1, exp_err, exp_lb);

        // Asynchronous reset mid-operation
        step(1'b0, 8'd0);
        step(1'b1, 8'd30);
        step(1'b1, 8'd31);
        step(1'b1, 8'd32); expect_out("prerst", 2, 1, 0, exp_err, exp_lb);
        #1 rst = 1'b0;
        #1;
        expect_out("midrst", 0, 0, 0, 0, 0);
        chk("midrst.sat_err_cnt", 32'(s_err_cnt), 32'd0);
        #4 rst = 1'b1;
        step(1'b1, 8'd77); expect_out("post77", 1, 0, 0, 0, 0);
        step(1'b1, 8'd78); expect_out("post78", 1, 0, 0, 0, 0);
        step(1'b1, 8'd79); expect_out("post79", 2, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule : tb_count_checker
`default_nettype wire
